// File: rtl/rgb_timing_rx.sv
// RGB565 parallel LCD receiver: two-stage capture into an x/y tagged pixel stream,
// with line/frame geometry measurement and a two-identical-frames lock detector.
module rgb_timing_rx #(
  parameter bit HS_ACTIVE_LOW = 1'b1,
  parameter bit VS_ACTIVE_LOW = 1'b1,
  parameter int CNT_W         = 16,
  parameter int TIMEOUT       = 4096
) (
  input  logic             PixelClk,
  input  logic             nRST,
  input  logic             LCD_DE,
  input  logic             LCD_HSYNC,
  input  logic             LCD_VSYNC,
  input  logic [4:0]       LCD_R,
  input  logic [5:0]       LCD_G,
  input  logic [4:0]       LCD_B,
  output logic             pix_valid,
  output logic [15:0]      pix_data,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             sof,
  output logic             eol,
  output logic [CNT_W-1:0] meas_htotal,
  output logic [CNT_W-1:0] meas_width,
  output logic [CNT_W-1:0] meas_vtotal,
  output logic [CNT_W-1:0] meas_height,
  output logic             locked
);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  typedef struct packed {
    logic [CNT_W-1:0] htotal;
    logic [CNT_W-1:0] width;
    logic [CNT_W-1:0] vtotal;
    logic [CNT_W-1:0] height;
  } geom_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int               TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]  TO_SAT  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic             de1, hs1, vs1, de1_d, hs1_d, vs1_d;
  logic [15:0]      rgb1;
  logic [CNT_W-1:0] h_cnt, x_cnt, y_cnt, v_cnt, frame_width;
  logic [TO_W-1:0]  to_cnt;
  logic             hs_seen, htot_valid, frame_started, width_bad, sof_pend;
  logic             hs_edge, vs_edge, de_fall, timeout_hit;
  logic             htot_fresh, cur_ok, frame_match, width_change, ref_ok;
  logic [CNT_W-1:0] htot_new, v_next;
  geom_t            cur_geom, ref_geom;
  state_t           state;

  // Stage 1: syncs are normalised so that 1 always means "active".
  // NOTE: every register here uses <= so all stages see the previous-cycle values.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      de1   <= 1'b0;
      hs1   <= 1'b0;
      vs1   <= 1'b0;
      rgb1  <= '0;
      de1_d <= 1'b0;
      hs1_d <= 1'b0;
      vs1_d <= 1'b0;
    end else begin
      de1   <= LCD_DE;
      hs1   <= LCD_HSYNC ^ HS_ACTIVE_LOW;
      vs1   <= LCD_VSYNC ^ VS_ACTIVE_LOW;
      rgb1  <= {LCD_R, LCD_G, LCD_B};
      de1_d <= de1;
      hs1_d <= hs1;
      vs1_d <= vs1;
    end
  end

  // NOTE: every variable gets a value on every path, so no latches are inferred.
  always_comb begin
    hs_edge         = hs1 & ~hs1_d;
    vs_edge         = vs1 & ~vs1_d;
    de_fall         = de1_d & ~de1;
    htot_new        = sat_inc(h_cnt);
    htot_fresh      = hs_edge && hs_seen;
    // A coincident line edge is folded in before the frame is evaluated.
    v_next          = hs_edge ? sat_inc(v_cnt) : v_cnt;
    cur_geom.htotal = htot_fresh ? htot_new : meas_htotal;
    cur_geom.width  = frame_width;
    cur_geom.vtotal = v_next;
    cur_geom.height = y_cnt;
    cur_ok          = frame_started && !width_bad && (htot_fresh || htot_valid) &&
                      (cur_geom.htotal != CNT_MAX);
    frame_match     = ref_ok && cur_ok && (cur_geom == ref_geom);
    width_change    = de_fall && (x_cnt != ref_geom.width);
    timeout_hit     = !hs_edge && (to_cnt == TO_LAST);
  end

  // Geometry counters and measurement registers.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      h_cnt         <= '0;
      x_cnt         <= '0;
      y_cnt         <= '0;
      v_cnt         <= '0;
      to_cnt        <= '0;
      frame_width   <= '0;
      hs_seen       <= 1'b0;
      htot_valid    <= 1'b0;
      frame_started <= 1'b0;
      width_bad     <= 1'b0;
      sof_pend      <= 1'b0;
      meas_htotal   <= '0;
      meas_width    <= '0;
      meas_vtotal   <= '0;
      meas_height   <= '0;
    end else begin
      h_cnt  <= hs_edge ? '0 : sat_inc(h_cnt);
      to_cnt <= hs_edge ? '0 : ((to_cnt == TO_SAT) ? to_cnt : to_cnt + 1'b1);
      x_cnt  <= de1 ? sat_inc(x_cnt) : '0;
      v_cnt  <= v_next;
      if (hs_edge) hs_seen <= 1'b1;
      if (htot_fresh) begin
        meas_htotal <= htot_new;
        htot_valid  <= 1'b1;
      end
      if (de_fall) begin
        meas_width <= x_cnt;
        y_cnt      <= sat_inc(y_cnt);
        if (y_cnt == '0) frame_width <= x_cnt;
        else if (x_cnt != frame_width) width_bad <= 1'b1;
      end
      if (de1) sof_pend <= 1'b0;
      if (vs_edge) begin
        meas_vtotal   <= v_next;
        meas_height   <= y_cnt;
        v_cnt         <= '0;
        y_cnt         <= '0;
        frame_width   <= '0;
        width_bad     <= 1'b0;
        frame_started <= 1'b1;
        sof_pend      <= !de1;
      end
    end
  end

  // Stage 2: pixel outputs. eol looks one cycle ahead at the DE pin itself.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      pix_valid <= 1'b0;
      pix_data  <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      sof       <= 1'b0;
      eol       <= 1'b0;
    end else begin
      pix_valid <= de1;
      pix_data  <= rgb1;
      pix_x     <= de1 ? x_cnt : '0;
      pix_y     <= (de1 && !vs_edge) ? y_cnt : '0;
      sof       <= de1 && (sof_pend || vs_edge);
      eol       <= de1 && !LCD_DE;
    end
  end

  // Lock FSM: a reference frame must be followed by an identical, clean frame.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      state    <= SEARCH;
      locked   <= 1'b0;
      ref_geom <= '0;
      ref_ok   <= 1'b0;
    end else begin
      unique case (state)
        SEARCH: begin
          if (vs_edge) begin
            ref_geom <= cur_geom;
            ref_ok   <= cur_ok;
            state    <= CHECK;
          end
        end
        CHECK: begin
          if (vs_edge) begin
            if (frame_match) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end else begin
              ref_geom <= cur_geom;
              ref_ok   <= cur_ok;
            end
          end
        end
        LOCKED: begin
          if (timeout_hit || width_change || (vs_edge && !frame_match)) begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule
